// File: rtl/alarm_event_decoder.sv
// alarm_event_decoder
//   Watches the three zone buzzer lines, measures each pulse, and queues one
//   {err, zone, len} event per pulse in a small FIFO drained by valid/ready.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_ena         block enable; low freezes all state (except overflow clear)
//   i_buzz[2:0]   buzzer lines {zone3, zone2, zone1}
//   o_evt_valid   FIFO non-empty
//   i_evt_ready   consumer accepts head event
//   o_evt_zone    head event zone (1..3, 0 = invalid pattern)
//   o_evt_len     head event length in cycles, saturating at 63
//   o_evt_err     head event malformed
//   o_overflow    sticky: an event was dropped on a full FIFO
//   i_clear_ovf   synchronous clear of o_overflow
//   o_busy        measuring a pulse
module alarm_event_decoder #(
    parameter int unsigned PULSE_MIN  = 28,
    parameter int unsigned PULSE_MAX  = 34,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic [2:0] i_buzz,
    output logic       o_evt_valid,
    input  logic       i_evt_ready,
    output logic [1:0] o_evt_zone,
    output logic [5:0] o_evt_len,
    output logic       o_evt_err,
    output logic       o_overflow,
    input  logic       i_clear_ovf,
    output logic       o_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [5:0] MIN_C = 6'(PULSE_MIN);
    localparam logic [5:0] MAX_C = 6'(PULSE_MAX);

    typedef enum logic [1:0] {StSync, StIdle, StMeasure} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0] r_pat;
    logic [5:0] r_len;

    logic       w_push;
    logic       w_chg;
    logic [1:0] w_zone;
    logic       w_err;
    logic [8:0] w_entry;

    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic       w_full;
    logic       w_pop;
    logic       w_push_ok;
    logic       w_drop;
    logic [8:0] w_head;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StSync;
        end else if (i_ena) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSync:    if (i_buzz == 3'b000) w_state_next = StIdle;
            StIdle:    if (i_buzz != 3'b000) w_state_next = StMeasure;
            StMeasure: begin
                if (i_buzz == 3'b000) begin
                    w_state_next = StIdle;
                end else if (i_buzz != r_pat) begin
                    // Pattern changed mid-pulse: resync so the new segment is not logged
                    w_state_next = StSync;
                end
            end
            default:   w_state_next = StSync;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (r_state == StMeasure);
        w_push = (r_state == StMeasure) && (i_buzz != r_pat);
        w_chg  = (i_buzz != 3'b000);
    end

    // Pulse pattern and length counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pat <= 3'b000;
            r_len <= 6'd0;
        end else if (i_ena) begin
            if (r_state == StIdle && i_buzz != 3'b000) begin
                r_pat <= i_buzz;
                r_len <= 6'd1;
            end else if (r_state == StMeasure && i_buzz == r_pat && r_len != 6'd63) begin
                r_len <= r_len + 6'd1;
            end
        end
    end

    always_comb begin
        case (r_pat)
            3'b001:  w_zone = 2'd1;
            3'b010:  w_zone = 2'd2;
            3'b100:  w_zone = 2'd3;
            default: w_zone = 2'd0;
        endcase
        w_err   = (w_zone == 2'd0) | w_chg | (r_len < MIN_C) | (r_len > MAX_C);
        w_entry = {w_err, w_zone, r_len};
    end

    // Event FIFO
    always_comb begin
        o_evt_valid = (r_count != '0);
        w_full      = (r_count == FULL_C);
        w_pop       = o_evt_valid & i_evt_ready & i_ena;
        // A full FIFO still accepts a push if the head leaves on the same edge
        w_push_ok   = w_push & i_ena & (~w_full | w_pop);
        w_drop      = w_push & i_ena & w_full & ~w_pop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overflow; a drop on the same edge as a clear wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_head     = o_evt_valid ? r_mem[r_rptr] : 9'd0;
        o_evt_err  = w_head[8];
        o_evt_zone = w_head[7:6];
        o_evt_len  = w_head[5:0];
        o_overflow = r_overflow;
    end

endmodule

// File: tb/tb_alarm_event_decoder.sv
module tb_alarm_event_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [2:0] buzz = 3'b000;
    logic       evt_ready = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_zone;
    logic [5:0] evt_len;
    logic       evt_err;
    logic       overflow;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    alarm_event_decoder #(
        .PULSE_MIN (28),
        .PULSE_MAX (34),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ena      (ena),
        .i_buzz     (buzz),
        .o_evt_valid(evt_valid),
        .i_evt_ready(evt_ready),
        .o_evt_zone (evt_zone),
        .o_evt_len  (evt_len),
        .o_evt_err  (evt_err),
        .o_overflow (overflow),
        .i_clear_ovf(clear_ovf),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a pulse of n cycles, then one zero cycle (the edge that pushes)
    task automatic pulse(input logic [2:0] pat, input int n);
        buzz = pat;
        repeat (n) step();
        buzz = 3'b000;
        step();
    endtask

    task automatic pop_check(input string tag, input logic [1:0] z, input logic [5:0] l,
                             input logic e);
        chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
        chk({tag, ".zone"}, 32'(evt_zone), 32'(z));
        chk({tag, ".len"}, 32'(evt_len), 32'(l));
        chk({tag, ".err"}, 32'(evt_err), 32'(e));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst.valid", 32'(evt_valid), 32'd0);
        chk("rst.zone", 32'(evt_zone), 32'd0);
        chk("rst.len", 32'(evt_len), 32'd0);
        chk("rst.err", 32'(evt_err), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic legal pulse with latency and busy window
        buzz = 3'b001;
        chk("p1.busy_pre", 32'(busy), 32'd0);
        step();
        chk("p1.busy_first", 32'(busy), 32'd1);
        repeat (30) step();
        buzz = 3'b000;
        chk("p1.valid_pre", 32'(evt_valid), 32'd0);
        chk("p1.busy_last", 32'(busy), 32'd1);
        step();
        chk("p1.busy_post", 32'(busy), 32'd0);
        pop_check("p1", 2'd1, 6'd31, 1'b0);
        chk("p1.empty", 32'(evt_valid), 32'd0);

        // Legality window on zone 2
        pulse(3'b010, 27);
        pulse(3'b010, 28);
        pulse(3'b010, 34);
        pulse(3'b010, 35);
        chk("win.ovf", 32'(overflow), 32'd0);
        pop_check("win27", 2'd2, 6'd27, 1'b1);
        pop_check("win28", 2'd2, 6'd28, 1'b0);
        pop_check("win34", 2'd2, 6'd34, 1'b0);
        pop_check("win35", 2'd2, 6'd35, 1'b1);
        chk("win.empty", 32'(evt_valid), 32'd0);

        // Non-one-hot pattern
        pulse(3'b011, 31);
        pop_check("bad011", 2'd0, 6'd31, 1'b1);

        // Pattern change mid-pulse: one event, second segment ignored
        buzz = 3'b100;
        repeat (10) step();
        buzz = 3'b010;
        repeat (5) step();
        chk("chg.busy_sync", 32'(busy), 32'd0);
        buzz = 3'b000;
        step();
        step();
        pop_check("chg", 2'd3, 6'd10, 1'b1);
        chk("chg.empty", 32'(evt_valid), 32'd0);

        // Overflow: fifth event dropped, order preserved
        for (int i = 0; i < 5; i++) pulse(3'b001, 29 + i);
        chk("ovf.set", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf.clr", 32'(overflow), 32'd0);
        pop_check("ovf0", 2'd1, 6'd29, 1'b0);
        pop_check("ovf1", 2'd1, 6'd30, 1'b0);
        pop_check("ovf2", 2'd1, 6'd31, 1'b0);
        pop_check("ovf3", 2'd1, 6'd32, 1'b0);
        chk("ovf.empty", 32'(evt_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) pulse(3'b100, 28 + i);
        buzz = 3'b100;
        repeat (15) step();
        chk("full.head_len", 32'(evt_len), 32'd28);
        repeat (17) step();
        buzz = 3'b000;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("full.ovf", 32'(overflow), 32'd0);
        pop_check("full0", 2'd3, 6'd29, 1'b0);
        pop_check("full1", 2'd3, 6'd30, 1'b0);
        pop_check("full2", 2'd3, 6'd31, 1'b0);
        pop_check("full3", 2'd3, 6'd32, 1'b0);
        chk("full.empty", 32'(evt_valid), 32'd0);

        // Length saturation
        pulse(3'b001, 70);
        pop_check("sat", 2'd1, 6'd63, 1'b1);

        // ena low mid-measure freezes counting
        buzz = 3'b010;
        repeat (10) step();
        ena = 1'b0;
        repeat (5) step();
        ena = 1'b1;
        repeat (10) step();
        buzz = 3'b000;
        step();
        pop_check("ena", 2'd2, 6'd20, 1'b1);

        // Reset mid-pulse with an event pending
        pulse(3'b100, 30);
        chk("rmp.valid_pre", 32'(evt_valid), 32'd1);
        buzz = 3'b001;
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("rmp.valid", 32'(evt_valid), 32'd0);
        chk("rmp.len", 32'(evt_len), 32'd0);
        chk("rmp.busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("rmp.busy_sync", 32'(busy), 32'd0);
        buzz = 3'b000;
        step();
        step();
        chk("rmp.no_evt", 32'(evt_valid), 32'd0);
        pulse(3'b001, 31);
        pop_check("rmp.clean", 2'd1, 6'd31, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_event_decoder.md
# alarm_event_decoder

Listening end of the zone-alarm buzzer interface. It monitors the three buzzer lines that the sensor-debounce/alarm block drives. Each buzzer pulse becomes a zone event with a validated length, queued in a small FIFO. Events drain through a valid/ready port toward the status/logging logic.

## Interface

Parameters:
- PULSE_MIN, 28: shortest legal pulse length in cycles, inclusive.
- PULSE_MAX, 34: longest legal pulse length in cycles, inclusive. Must be ≤ 62.
- FIFO_DEPTH, 4: event queue depth. Power of 2, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset. Clears all state immediately.
- ena  in  1  block enable. Low freezes all state and ignores evt_ready.
- buzz  in  3  buzzer lines {zone3, zone2, zone1}. Synchronous to clk. One-hot or zero when legal.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_zone  out  2  head event zone: 1, 2 or 3; 0 when invalid.
- evt_len  out  6  head event pulse length in cycles, saturating at 63.
- evt_err  out  1  head event malformed.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_ovf  in  1  synchronous clear of overflow.
- busy  out  1  FSM in MEASURE.

## Operation

- All registers update only when ena=1. The single exception is clear_ovf, which acts regardless of ena.
- FSM states:
  - SYNC (reset state):
    - wait for buzz==0.
    - buzz==0 → IDLE.
    - Purpose: a pulse already in progress at reset release is never logged.
  - IDLE:
    - buzz≠0 → MEASURE.
    - On that edge: pat←buzz, len←1.
  - MEASURE:
    - buzz==pat: len←min(len+1, 63), stay.
    - buzz==0: push event, → IDLE.
    - buzz≠0 and buzz≠pat: push event with chg=1, → SYNC.
- Event fields at push:
  - zone = 1, 2 or 3 for pat = 001, 010, 100 respectively. zone = 0 for any other pat.
  - len = the counted length.
  - err = (zone==0) | chg | (len<PULSE_MIN) | (len>PULSE_MAX).
- FIFO (FIFO_DEPTH entries, each {err, zone, len}):
  - Push when not full, or when full and a pop occurs on the same edge.
  - Otherwise the event is dropped and overflow←1.
  - Pop when evt_valid & evt_ready & ena.
  - Push and pop on the same edge: count unchanged, both performed.
  - Pointers wrap modulo FIFO_DEPTH.
- Output port:
  - evt_zone, evt_len and evt_err always show the head entry. They are 0 when empty.
  - The head is stable while evt_valid=1 and evt_ready=0.
- overflow:
  - clear_ovf=1 clears it.
  - If a drop occurs on the same edge as clear_ovf, set wins.

## Timing

- Reset values: evt_valid=0, evt_zone=0, evt_len=0, evt_err=0, overflow=0, busy=0. FSM=SYNC. FIFO empty, pointers 0.
- Pulse latency:
  - buzz goes high, first sampled at edge t.
  - buzz is sampled 0 at edge t+N.
  - The event records len=N and is written at edge t+N.
  - evt_valid is high after edge t+N (from cycle t+N+1) when the FIFO was empty.
- busy is high from cycle t+1 through cycle t+N.
- Back-to-back pulses:
  - One zero cycle between pulses is sufficient.
  - The IDLE→MEASURE transition occurs on the first nonzero sample after the push.
- Length saturation: len holds at 63. Any pulse ≥ 63 cycles reports len=63, err=1.
- ena=0 during MEASURE:
  - The cycle is not counted.
  - The FSM resumes on return of ena.
- rst asserted mid-pulse:
  - All state clears asynchronously.
  - After release, the FSM sits in SYNC until buzz==0, so the truncated pulse produces no event.
- Pop throughput: one event per cycle while evt_ready=1.

## Test plan

- buzz=001 for 31 cycles, then 0, with evt_ready=0 → one event: zone=1, len=31, err=0. evt_valid rises 1 cycle after the falling sample.
- Legality window: pulses of 27, 28, 34, 35 cycles on zone 2 → len = 27/28/34/35 with err = 1/0/0/1.
- Malformed pulses:
  - buzz=011 for 31 cycles → zone=0, err=1.
  - buzz=100 for 10 cycles then 010 → event zone=3, len=10, err=1. FSM passes through SYNC; no event for the 010 segment.
- Overflow: 5 legal pulses with evt_ready=0 and FIFO_DEPTH=4 → 4 events held, overflow=1. clear_ovf pulse → overflow=0. Draining yields the 4 events in order.
- Full FIFO: push and pop on the same edge → count stays 4, no drop, overflow stays 0.
- Reset mid-pulse: rst asserted at cycle 10 of a 31-cycle pulse → outputs 0 immediately, no event logged. The next clean 31-cycle pulse → zone correct, err=0.
